// File: rtl/mux_scan_capture16_pkg.sv
// Shared types and defaults for the 16:1 select-mux scan capture block.
package mux_scan_capture16_pkg;

  localparam int unsigned N_CH  = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_capture16_settle_timer.sv
// Loadable down-counter with a zero flag; paces the settle wait per channel.
module mux_scan_capture16_settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_capture16.sv
// Scans a remote 16:1 mux by stepping its select, samples f per channel and
// publishes each complete 16-bit frame atomically on w_o.
module mux_scan_capture16
  import mux_scan_capture16_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             abort_i,
  output logic [SEL_W-1:0] s_o,
  input  logic             f_i,
  output logic [N_CH-1:0]  w_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N_CH - 1);
  localparam logic [3:0]       SETTLE_LD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam state_e           FIRST_ST  = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  state_e           state_q;
  logic [SEL_W-1:0] s_q;
  logic [N_CH-2:0]  shadow_q;
  logic [N_CH-1:0]  w_q;
  logic             busy_q, done_q, cont_q;
  logic             tmr_load, tmr_zero;

  // Reload on every entry to a channel; only the SETTLE state consumes it.
  assign tmr_load = !abort_i &&
                    (((state_q == ST_IDLE) && start_i) || (state_q == ST_SAMPLE));

  mux_scan_capture16_settle_timer #(.W(4)) u_settle_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LD),
    .en_i       (state_q == ST_SETTLE),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      shadow_q <= '0;
      w_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cont_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
        s_q     <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              cont_q  <= cont_i;
              busy_q  <= 1'b1;
              s_q     <= '0;
              state_q <= FIRST_ST;
            end
          end
          ST_SETTLE: begin
            if (tmr_zero) state_q <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            if (s_q != LAST_CH) begin
              shadow_q[s_q] <= f_i;
              s_q           <= s_q + 1'b1;
              state_q       <= FIRST_ST;
            end else begin
              // Last channel bypasses the shadow so w updates in one edge.
              w_q    <= {f_i, shadow_q};
              done_q <= 1'b1;
              s_q    <= '0;
              if (cont_q) begin
                state_q <= FIRST_ST;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_o    = s_q;
  assign w_o    = w_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_mux_scan_capture16.sv
// Directed bench for mux_scan_capture16; a behavioural 16:1 mux supplies f.
module tb_mux_scan_capture16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start1 = 0, cont1 = 0, abort1 = 0;
  logic [3:0]  s1;
  logic [15:0] w1, src1 = '0;
  logic        f1, busy1, done1;

  logic        start0 = 0, cont0 = 0, abort0 = 0;
  logic [3:0]  s0;
  logic [15:0] w0, src0 = '0;
  logic        f0, busy0, done0;

  int n_vec = 0;
  int n_err = 0;
  int n;
  int seen;

  always #5 clk = ~clk;

  assign f1 = src1[s1];
  assign f0 = src0[s0];

  mux_scan_capture16 #(.SETTLE(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .cont_i(cont1), .abort_i(abort1),
    .s_o(s1), .f_i(f1), .w_o(w1), .busy_o(busy1), .done_o(done1)
  );

  mux_scan_capture16 #(.SETTLE(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .cont_i(cont0), .abort_i(abort0),
    .s_o(s0), .f_i(f0), .w_o(w0), .busy_o(busy0), .done_o(done0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the start-accept edge until done1 is seen (bounded).
  task automatic wait_done1(input int n0, output int cnt);
    cnt = n0;
    do begin
      tick();
      cnt++;
    end while (!done1 && cnt < 100);
  endtask

  task automatic start_dut1(input logic c);
    start1 = 1'b1;
    cont1  = c;
    tick();
    start1 = 1'b0;
    cont1  = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_s", s1, 0);
    chk("rst_w", w1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    rst_n = 1'b1;
    tick();

    // single frame, SETTLE=1
    src1 = 16'hA5C3;
    start_dut1(1'b0);
    chk("busy_after_start", busy1, 1);
    wait_done1(0, n);
    chk("single_latency", n, 32);
    chk("single_w", w1, 16'hA5C3);
    chk("single_s", s1, 0);
    chk("single_busy", busy1, 0);
    tick();
    chk("done_pulse_1cyc", done1, 0);

    // SETTLE=0 variant, exercises the s=15 wrap
    src0   = 16'h8001;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done0 && n < 100);
    chk("s0_latency", n, 16);
    chk("s0_w", w0, 16'h8001);
    chk("s0_s_wrap", s0, 0);

    // continuous: back-to-back frames, source swapped between them
    src1 = 16'h1234;
    start_dut1(1'b1);
    wait_done1(0, n);
    chk("cont_first_lat", n, 32);
    chk("cont_first_w", w1, 16'h1234);
    chk("cont_no_gap_busy", busy1, 1);
    src1 = 16'hFEDC;
    wait_done1(0, n);
    chk("cont_period", n, 32);
    chk("cont_second_w", w1, 16'hFEDC);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("cont_abort_busy", busy1, 0);
    chk("cont_abort_w", w1, 16'hFEDC);

    // abort mid-frame keeps the previous frame
    src1 = 16'h00FF;
    start_dut1(1'b0);
    wait_done1(0, n);
    chk("ff_w", w1, 16'h00FF);
    src1 = 16'hFFFF;
    start_dut1(1'b0);
    n = 0;
    while (s1 != 4'd7 && n < 40) begin
      tick();
      n++;
    end
    chk("reach_s7", s1, 7);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort_s", s1, 0);
    chk("abort_busy", busy1, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1) seen++;
      tick();
    end
    chk("abort_no_done", seen, 0);
    chk("abort_w_kept", w1, 16'h00FF);

    // start while busy is ignored
    src1 = 16'h3C5A;
    start_dut1(1'b0);
    for (int i = 0; i < 10; i++) tick();
    start1 = 1'b1;
    cont1  = 1'b1;
    tick();
    start1 = 1'b0;
    cont1  = 1'b0;
    wait_done1(11, n);
    chk("busy_start_lat", n, 32);
    chk("busy_start_w", w1, 16'h3C5A);
    chk("busy_start_single", busy1, 0);

    // abort coinciding with the final SAMPLE edge
    src1 = 16'h1111;
    start_dut1(1'b0);
    for (int i = 0; i < 31; i++) tick();
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort_last_done", done1, 0);
    chk("abort_last_w", w1, 16'h3C5A);
    chk("abort_last_busy", busy1, 0);

    // asynchronous reset mid-frame, then a clean frame
    src1 = 16'h5AA5;
    start_dut1(1'b0);
    n = 0;
    while (s1 != 4'd9 && n < 40) begin
      tick();
      n++;
    end
    chk("reach_s9", s1, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s", s1, 0);
    chk("arst_w", w1, 0);
    chk("arst_busy", busy1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_dut1(1'b0);
    wait_done1(0, n);
    chk("post_rst_lat", n, 32);
    chk("post_rst_w", w1, 16'h5AA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
